imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, is the instruction memory depth in 32-bit words.
REQ-002 Parameter AW, default 32, is the byte-address width presented to instruction memory.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 load_start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 base_addr  input  AW  byte start address, sampled with load_start; bits [1:0] ignored.
REQ-007 word_count  input  11  number of words to load, sampled with load_start.
REQ-008 abort  input  1  cancels an in-progress load.
REQ-009 byte_valid  input  1  byte source has a byte on byte_data.
REQ-010 byte_data  input  8  program byte, most-significant byte of each word first.
REQ-011 byte_ready  output  1  loader accepts byte_data this cycle.
REQ-012 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-013 imem_addr  output  AW  word-aligned byte address of the write.
REQ-014 imem_wdata  output  32  assembled instruction word.
REQ-015 cpu_hold  output  1  holds the CPU (PC/fetch) while the loader owns the memory.
REQ-016 busy  output  1  load in progress.
REQ-017 done  output  1  one-cycle pulse on successful completion.
REQ-018 err  output  1  one-cycle pulse on rejected start or abort.

Function
REQ-019 FSM states SHALL be IDLE, COLLECT, WRITE, FINISH.
REQ-020 IDLE: load_start with 1 <= word_count <= DEPTH_WORDS -> COLLECT; latch base_addr with [1:0]=00, clear byte and word counters.
REQ-021 IDLE: load_start with word_count=0 -> FINISH, with no writes.
REQ-022 IDLE: load_start with word_count > DEPTH_WORDS -> err pulse next cycle, stay IDLE.
REQ-023 byte_ready SHALL be 1 only in COLLECT; a byte is accepted iff byte_valid && byte_ready.
REQ-024 Accepted bytes shift into the word MSB-first: byte 0 -> [31:24], byte 3 -> [7:0].
REQ-025 On acceptance of the 4th byte -> WRITE in the next cycle.
REQ-026 WRITE (exactly one cycle): imem_we=1, imem_addr=current address, imem_wdata=assembled word, byte_ready=0.
REQ-027 After WRITE, address += 4, wrapping modulo 4*DEPTH_WORDS relative to 0; words_written += 1.
REQ-028 After WRITE: words_written == word_count -> FINISH, else -> COLLECT.
REQ-029 FINISH: done=1 for one cycle, then IDLE.
REQ-030 busy and cpu_hold SHALL be 1 in COLLECT, WRITE and FINISH, and 0 in IDLE.
REQ-031 load_start outside IDLE SHALL be ignored, with no err.
REQ-032 abort in COLLECT or WRITE -> IDLE next cycle, partial word discarded, err pulse; in WRITE the write still completes that cycle.
REQ-033 abort and load_start in IDLE together: abort wins, no load starts, no err.
REQ-034 Byte stalls (byte_valid=0) of any length SHALL NOT change state or data.
REQ-035 Throughput SHALL be 5 cycles per word with continuous byte_valid.

Reset
REQ-036 rst_n=0 SHALL force IDLE and byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, busy=0, done=0, err=0, all counters 0.
REQ-037 Reset mid-load SHALL discard all progress; no write occurs after reset assertion.

Structure
REQ-038 FSM state encoding and the default DEPTH_WORDS value SHALL live in the shared CPU package.
REQ-039 The byte-to-word assembler SHALL be sub-module imem_word_packer (shift register plus 2-bit byte counter).

Verification
REQ-040 base=0x100, count=2, bytes 00 50 05 13 00 10 01 13 back-to-back -> writes (0x100, 0x00500513) and (0x104, 0x00100113), done 10 cycles after the first byte.
REQ-041 count=1 with byte_valid gapped 3 cycles between bytes -> single write 0xDEADBEEF (bytes DE AD BE EF) at base, cpu_hold=1 throughout.
REQ-042 count=0 -> no imem_we, done pulse 1 cycle after start; count=1025 -> err pulse, busy stays 0.
REQ-043 base=0xFFC, count=2 -> writes at 0xFFC, then 0x000 (wrap).
REQ-044 abort after 2 bytes of word 2 -> only word 1 written, err pulse, IDLE; a new load then succeeds.
REQ-045 rst_n low after 3 bytes -> all outputs 0 immediately, no write, IDLE on release.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and
// default memory geometry.
package imem_loader_pkg;

    localparam int DEFAULT_DEPTH_WORDS = 1024;
    localparam int WORD_COUNT_W        = 11;
    localparam int BYTES_PER_WORD      = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        FINISH  = 2'd3
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The master side is the loader itself.
interface imem_loader_if #(
    parameter int AW = 32
);
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_word_packer.sv
// Assembles four bytes, most-significant first, into a 32-bit word and flags
// the byte that completes it.
module imem_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        last
);

    logic [1:0] byte_cnt;

    assign last = shift_en && (byte_cnt == 2'd3);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            word     <= {word[23:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory one word at a time while
// holding the CPU off the memory.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int AW          = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_start,
    input  logic [AW-1:0]           base_addr,
    input  logic [WORD_COUNT_W-1:0] word_count,
    input  logic                    abort,
    imem_loader_if.master           bus,
    output logic                    cpu_hold,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam logic [AW:0] WRAP_BYTES  = (AW+1)'(BYTES_PER_WORD * DEPTH_WORDS);
    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

    state_t                  state;
    logic [AW-1:0]           addr_q;
    logic [AW-1:0]           addr_next;
    logic [WORD_COUNT_W-1:0] target_q;
    logic [WORD_COUNT_W-1:0] written_q;
    logic [WORD_COUNT_W-1:0] written_inc;
    logic                    ready_q;
    logic                    we_q;
    logic                    count_too_big;
    logic                    pk_clear;
    logic                    pk_shift;
    logic                    pk_last;
    logic [31:0]             pk_word;

    // Address wraps within the memory image, independent of where the load began.
    assign addr_next     = AW'(({1'b0, addr_q} + (AW+1)'(BYTES_PER_WORD)) % WRAP_BYTES);
    assign written_inc   = written_q + 1'b1;
    assign count_too_big = 32'(word_count) > DEPTH_LIMIT;

    assign pk_shift = bus.byte_valid && ready_q;
    assign pk_clear = (state == IDLE) || abort;

    imem_word_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (pk_clear),
        .shift_en (pk_shift),
        .byte_in  (bus.byte_data),
        .word     (pk_word),
        .last     (pk_last)
    );

    assign bus.byte_ready = ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = pk_word;
    assign cpu_hold       = busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            target_q  <= '0;
            written_q <= '0;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here so each assignment below lasts one cycle.
            we_q <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!abort && load_start) begin
                        if (word_count == '0) begin
                            state <= FINISH;
                            busy  <= 1'b1;
                            done  <= 1'b1;
                        end else if (count_too_big) begin
                            err <= 1'b1;
                        end else begin
                            state     <= COLLECT;
                            addr_q    <= base_addr & ~AW'(3);
                            target_q  <= word_count;
                            written_q <= '0;
                            ready_q   <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (abort) begin
                        state   <= IDLE;
                        ready_q <= 1'b0;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                    end else if (pk_last) begin
                        state   <= WRITE;
                        ready_q <= 1'b0;
                        we_q    <= 1'b1;
                    end
                end
                WRITE: begin
                    addr_q    <= addr_next;
                    written_q <= written_inc;
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else if (written_inc == target_q) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        state   <= COLLECT;
                        ready_q <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
